ahb_lite_mem_arbiter: RTL
=========================

# ahb_lite_mem_arbiter

Two-port round-robin arbiter and AHB-Lite master sequencer for the AHB-Lite memory slave. Two local requesters post single-word read/write requests on a level req / pulse ack interface. The block grants one requester at a time, drives a single NONSEQ transfer with address phase then data phase into the slave, absorbs HREADY wait states and HRESP errors, and returns read data and status to the granted requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 16, data-phase watchdog limit; used only with ARB_TIMEOUT_EN
- HCLK  in  1  clock; single clock domain
- HRESETn  in  1  synchronous, active-low reset
- req  in  2  per-requester request level; bit i is requester i
- we  in  2  1 = write, 0 = read; per requester
- addr  in  2*ADDR_W  packed per-requester addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  packed per-requester write data
- ack  out  2  one-cycle completion pulse to the granted requester
- err  out  1  completion status; valid only while ack is nonzero
- rdata  out  DATA_W  read data; valid while ack is nonzero after a read
- HSEL, HADDR, HWRITE, HWDATA, HTRANS  out  1/ADDR_W/1/DATA_W/2  AHB-Lite master outputs to the slave
- HSIZE  out  3  constant 3'b010
- WORK  out  1  slave enable; 0 in reset, 1 from the first cycle after reset release
- HRDATA, HREADY, HRESP  in  DATA_W/1/1  slave responses

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: samples req. If no request, stay in IDLE. Otherwise:
  - rr_arbiter2 picks the winner. The priority pointer names the last-granted requester and resets to 1, so requester 0 wins the first tie.
  - On a tie, the requester not named by the pointer wins. The pointer updates to the winner.
  - Capture we, addr and wdata of the winner.
  - If captured addr[1:0] != 0, go directly to RESP with err=1 and issue no bus transfer. Otherwise go to ADDR.
- ADDR: HSEL=1, HTRANS=2'b10, HADDR and HWRITE come from the captured values. Go to DATA.
- DATA: HSEL=0, HTRANS=2'b00, HWDATA = captured wdata (writes only; 0 for reads).
  - Set a sticky error flag on any cycle with HRESP=1.
  - When HREADY=1, capture HRDATA (reads only) and go to RESP.
- RESP: ack[winner]=1 for exactly this cycle. err = sticky flag. rdata holds the captured data. Clear the flag and go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Drop req in the cycle after ack.
  - req is ignored outside IDLE, so there is no double issue.
  - A requester that deasserts req before ack still receives its ack.
- The non-granted requester waits. It wins the next IDLE decision if it is still requesting, which bounds starvation to one transfer.
- Reset outputs: HSEL=0, HADDR=0, HWRITE=0, HWDATA=0, HTRANS=2'b00, WORK=0, ack=2'b00, err=0, rdata=0, pointer=1, FSM=IDLE, sticky flag=0.
- Reset mid-transfer: all of the above apply at the next edge. The in-flight transfer is dropped and no ack is issued.

## Timing
- req high at edge k (FSM in IDLE) -> ADDR cycle k+1 -> DATA cycle k+2 -> RESP/ack cycle k+3 with zero wait states.
- Each HREADY=0 cycle in DATA adds one cycle.
- Minimum of 4 cycles per transfer; peak throughput is one transfer per 4 cycles.
- Misaligned request: req at edge k -> ack with err=1 in cycle k+1.
- AHB two-cycle error response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1): completes with err=1, latency +1.
- All outputs are registered. No combinational path from the slave inputs to ack, err or rdata.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in DATA and clears on entry to DATA.
  - If HREADY stays 0 for TIMEOUT_CYC consecutive cycles, the FSM forces RESP with err=1 and rdata=0.
  - HTRANS stays IDLE during this, so nothing further is issued to the slave.
- ARB_TIMEOUT_EN undefined: no counter; DATA waits for HREADY indefinitely.

## Structure
- Package ahb_arb_pkg holds:
  - HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10
  - HSIZE_WORD=3'b010
  - the FSM state enum
- Sub-module rr_arbiter2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: grant one-hot[1:0], grant_idx.
  - The pointer register lives in the parent.

## Test plan
- Requester 0 writes 0xDEADBEEF to 0x10, then reads 0x10, with HREADY=1 -> write ack at k+3; read ack with rdata=0xDEADBEEF and err=0.
- Requesters 0 and 1 both raise req in the same cycle, first after reset, each reading a different address -> requester 0 is acked first, requester 1 next; a repeated tie alternates 1, 0.
- Slave holds HREADY=0 for 3 cycles during a read of 0x20 -> ack at k+6 with the correct data; HTRANS=2'b00 throughout DATA.
- Slave returns a two-cycle HRESP error on a write -> ack with err=1; next transfer succeeds with err=0.
- Request with addr=0x13 -> ack at k+1 with err=1; HSEL is never asserted.
- HRESETn=0 asserted in DATA -> next cycle all outputs are at reset values with no ack. With ARB_TIMEOUT_EN, HREADY stuck at 0 -> ack with err=1 after exactly 16 DATA cycles.

Source files
------------

// File: rtl/ahb_lite_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_arb_pkg : shared AHB-Lite encodings and arbiter FSM state type |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_lite_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_lite_mem_arbiter_if : requester + AHB-Lite bundle, arbiter view |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
interface ahb_lite_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import ahb_arb_pkg::*;

  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          ack;
  logic                err;
  logic [DATA_W-1:0]   rdata;

  logic                HSEL;
  logic [ADDR_W-1:0]   HADDR;
  logic                HWRITE;
  logic [DATA_W-1:0]   HWDATA;
  logic [1:0]          HTRANS;
  logic [2:0]          HSIZE;
  logic                WORK;
  logic [DATA_W-1:0]   HRDATA;
  logic                HREADY;
  logic                HRESP;

  modport master (
    input  req, we, addr, wdata, HRDATA, HREADY, HRESP,
    output ack, err, rdata, HSEL, HADDR, HWRITE, HWDATA, HTRANS, HSIZE, WORK
  );

  modport slave (
    output req, we, addr, wdata, HRDATA, HREADY, HRESP,
    input  ack, err, rdata, HSEL, HADDR, HWRITE, HWDATA, HTRANS, HSIZE, WORK
  );

endinterface
`default_nettype wire

// File: rtl/ahb_lite_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2 : combinational two-way round-robin picker             |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module rr_arbiter2
  import ahb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    grant     = 2'b00;
    // On a tie the requester that was not granted last time goes first.
    if (req == 2'b11) begin
      grant_idx = ~last;
    end else begin
      grant_idx = req[1];
    end
    if (req != 2'b00) begin
      grant = 2'b01 << grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_lite_mem_arbiter : 2-port RR arbiter + AHB-Lite single-transfer |
// | sequencer; ARB_TIMEOUT_EN adds a data-phase watchdog. Rev 1.0       |
// +--------------------------------------------------------------------+
module ahb_lite_mem_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_lite_mem_arbiter_if.master bus
);

  arb_state_t r_state, w_state_nxt;

  logic              r_ptr,    w_ptr_nxt;
  logic [1:0]        r_grant,  w_grant_nxt;
  logic              r_we,     w_we_nxt;
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
  logic              r_sticky, w_sticky_nxt;

  logic              r_hsel,   w_hsel_nxt;
  logic [ADDR_W-1:0] r_haddr,  w_haddr_nxt;
  logic              r_hwrite, w_hwrite_nxt;
  logic [DATA_W-1:0] r_hwdata, w_hwdata_nxt;
  logic [1:0]        r_htrans, w_htrans_nxt;
  logic              r_work;
  logic [1:0]        r_ack,    w_ack_nxt;
  logic              r_err,    w_err_nxt;
  logic [DATA_W-1:0] r_rdata,  w_rdata_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
`endif

  logic [1:0]        w_grant;
  logic              w_grant_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;

  rr_arbiter2 u_rr (
    .req       (bus.req),
    .last      (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_sel_addr  = w_grant_idx ? bus.addr[2*ADDR_W-1:ADDR_W]  : bus.addr[ADDR_W-1:0];
  assign w_sel_wdata = w_grant_idx ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
  assign w_sel_we    = w_grant_idx ? bus.we[1] : bus.we[0];

  // Next values of every register are computed here so all bus and
  // requester outputs come straight from flops.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_sticky_nxt = r_sticky;
    w_hsel_nxt   = 1'b0;
    w_haddr_nxt  = '0;
    w_hwrite_nxt = 1'b0;
    w_hwdata_nxt = '0;
    w_htrans_nxt = HTRANS_IDLE;
    w_ack_nxt    = 2'b00;
    w_err_nxt    = 1'b0;
    w_rdata_nxt  = r_rdata;
`ifdef ARB_TIMEOUT_EN
    w_tcnt_nxt   = r_tcnt;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          w_ptr_nxt   = w_grant_idx;
          w_grant_nxt = w_grant;
          w_we_nxt    = w_sel_we;
          w_addr_nxt  = w_sel_addr;
          w_wdata_nxt = w_sel_wdata;
          if (w_sel_addr[1:0] != 2'b00) begin
            w_state_nxt = ST_RESP;
            w_ack_nxt   = w_grant;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = ST_ADDR;
            w_hsel_nxt   = 1'b1;
            w_htrans_nxt = HTRANS_NONSEQ;
            w_haddr_nxt  = w_sel_addr;
            w_hwrite_nxt = w_sel_we;
          end
        end
      end

      ST_ADDR: begin
        w_state_nxt  = ST_DATA;
        w_hwdata_nxt = r_we ? r_wdata : '0;
`ifdef ARB_TIMEOUT_EN
        w_tcnt_nxt   = '0;
`endif
      end

      ST_DATA: begin
        if (bus.HRESP) begin
          w_sticky_nxt = 1'b1;
        end
        if (bus.HREADY) begin
          w_state_nxt = ST_RESP;
          w_ack_nxt   = r_grant;
          w_err_nxt   = r_sticky | bus.HRESP;
          if (!r_we) begin
            w_rdata_nxt = bus.HRDATA;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = ST_RESP;
          w_ack_nxt   = r_grant;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_tcnt_nxt   = r_tcnt + 1'b1;
          w_hwdata_nxt = r_we ? r_wdata : '0;
`else
        end else begin
          w_hwdata_nxt = r_we ? r_wdata : '0;
`endif
        end
      end

      ST_RESP: begin
        w_state_nxt  = ST_IDLE;
        w_sticky_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 1'b1;
      r_grant  <= 2'b00;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sticky <= 1'b0;
      r_hsel   <= 1'b0;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hwdata <= '0;
      r_htrans <= HTRANS_IDLE;
      r_work   <= 1'b0;
      r_ack    <= 2'b00;
      r_err    <= 1'b0;
      r_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_tcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_sticky <= w_sticky_nxt;
      r_hsel   <= w_hsel_nxt;
      r_haddr  <= w_haddr_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_hwdata <= w_hwdata_nxt;
      r_htrans <= w_htrans_nxt;
      r_work   <= 1'b1;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_rdata  <= w_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
      r_tcnt   <= w_tcnt_nxt;
`endif
    end
  end

  assign bus.HSEL   = r_hsel;
  assign bus.HADDR  = r_haddr;
  assign bus.HWRITE = r_hwrite;
  assign bus.HWDATA = r_hwdata;
  assign bus.HTRANS = r_htrans;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.WORK   = r_work;
  assign bus.ack    = r_ack;
  assign bus.err    = r_err;
  assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire
